// File: rtl/add_err_pkg.sv
// Shared definitions for the approximate-adder error monitor: FSM states,
// derived-width helpers and the saturating add used by every accumulator.
package add_err_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic        ovf;
    logic [63:0] val;
  } sat_res_t;

  function automatic int err_width(input int w);
    return w + 1;
  endfunction

  function automatic int min_sum_width(input int cnt_w, input int w);
    return cnt_w + w;
  endfunction

  function automatic int sq_sum_width(input int sum_w, input int w);
    return sum_w + w + 1;
  endfunction

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 17;
  localparam int DEF_SUM_W = min_sum_width(DEF_CNT_W, DEF_WIDTH);

  // Clamps at the all-ones value of a w-bit field and reports the clamp.
  function automatic sat_res_t sat_add(input logic [63:0] acc,
                                       input logic [63:0] inc,
                                       input int          w);
    sat_res_t    r;
    logic [64:0] sum;
    logic [64:0] max_v;
    max_v = (65'd1 << w) - 65'd1;
    sum   = {1'b0, acc} + {1'b0, inc};
    if (sum > max_v) begin
      r.ovf = 1'b1;
      r.val = max_v[63:0];
    end else begin
      r.ovf = 1'b0;
      r.val = sum[63:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/add_err_calc.sv
// Two-stage registered datapath: exact sum of the operands, then the absolute
// distance between that exact result and the approximate result under test.
module add_err_calc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH:0]   in_o,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH:0]   out_err
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH:0]   s1_exact_q, s1_exact_d;
  logic [WIDTH:0]   s1_o_q, s1_o_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH:0]   s2_err_q, s2_err_d;
  logic [WIDTH+1:0] diff;
  logic [WIDTH+1:0] mag;
  logic             unused_mag_msb;

  // diff is a two's-complement value; its MSB is the sign, so the magnitude
  // always fits back into WIDTH+1 bits.
  always_comb begin
    s1_valid_d = in_valid;
    s1_exact_d = {1'b0, in_a} + {1'b0, in_b};
    s1_o_d     = in_o;
    diff       = {1'b0, s1_exact_q} - {1'b0, s1_o_q};
    mag        = diff[WIDTH+1] ? -diff : diff;
    s2_valid_d = s1_valid_q;
    s2_err_d   = mag[WIDTH:0];
  end

  assign unused_mag_msb = mag[WIDTH+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_exact_q <= '0;
      s1_o_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_err_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_exact_q <= s1_exact_d;
      s1_o_q     <= s1_o_d;
      s2_valid_q <= s2_valid_d;
      s2_err_q   <= s2_err_d;
    end
  end

  assign busy      = s1_valid_q | s2_valid_q;
  assign out_valid = s2_valid_q;
  assign out_err   = s2_err_q;

endmodule

// File: rtl/add8u_err_monitor.sv
// Streaming error-characterisation engine for approximate unsigned adders.
// Define ADD_ERR_MSE_EN to add the squared-error accumulator (err_sq_sum).
module add8u_err_monitor
  import add_err_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int SUM_W = DEF_SUM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH:0]   in_o,
  input  logic             in_last,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [SUM_W-1:0] err_sum,
  output logic [WIDTH:0]   err_max,
`ifdef ADD_ERR_MSE_EN
  output logic [SUM_W+WIDTH:0] err_sq_sum,
`endif
  output logic             sat
);

  localparam int ERR_W = err_width(WIDTH);

  state_e             state_q, state_d;
  logic               accept;
  logic               clear;
  logic               pipe_busy;
  logic               calc_busy;
  logic               calc_valid;
  logic [ERR_W-1:0]   calc_err;
  logic               upd_valid_q, upd_valid_d;
  logic [ERR_W-1:0]   upd_err_q, upd_err_d;
  logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [SUM_W-1:0]   err_sum_q, err_sum_d;
  logic [ERR_W-1:0]   err_max_q, err_max_d;
  logic               sat_q, sat_d;
  logic               sq_ovf;
  sat_res_t           r_cnt, r_ecnt, r_sum;
  logic               unused_sat_hi;

  assign accept = in_valid && (state_q == ST_RUN);
  assign clear  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  add_err_calc #(
    .WIDTH (WIDTH)
  ) u_calc (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_o      (in_o),
    .busy      (calc_busy),
    .out_valid (calc_valid),
    .out_err   (calc_err)
  );

`ifdef ADD_ERR_MSE_EN
  localparam int SQ_W = sq_sum_width(SUM_W, WIDTH);

  logic               sq_valid_q, sq_valid_d;
  logic [ERR_W-1:0]   sq_err_q, sq_err_d;
  logic [2*ERR_W-1:0] sq_prod_q, sq_prod_d;
  logic [2*ERR_W-1:0] upd_sq_q, upd_sq_d;
  logic [SQ_W-1:0]    err_sq_sum_q, err_sq_sum_d;
  sat_res_t           r_sq;
  logic               unused_sq_hi;

  // The squaring stage sits between the error stage and the update register.
  always_comb begin
    sq_valid_d   = calc_valid;
    sq_err_d     = calc_err;
    sq_prod_d    = {{ERR_W{1'b0}}, calc_err} * {{ERR_W{1'b0}}, calc_err};
    upd_valid_d  = sq_valid_q;
    upd_err_d    = sq_err_q;
    upd_sq_d     = sq_prod_q;
    r_sq         = sat_add(64'(err_sq_sum_q), 64'(upd_sq_q), SQ_W);
    sq_ovf       = upd_valid_q && r_sq.ovf;
    err_sq_sum_d = err_sq_sum_q;
    if (clear) begin
      err_sq_sum_d = '0;
    end else if (upd_valid_q) begin
      err_sq_sum_d = r_sq.val[SQ_W-1:0];
    end
  end

  assign pipe_busy    = calc_busy | sq_valid_q | upd_valid_q;
  assign unused_sq_hi = ^r_sq.val[63:SQ_W];
  assign err_sq_sum   = err_sq_sum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sq_valid_q   <= 1'b0;
      sq_err_q     <= '0;
      sq_prod_q    <= '0;
      upd_sq_q     <= '0;
      err_sq_sum_q <= '0;
    end else begin
      sq_valid_q   <= sq_valid_d;
      sq_err_q     <= sq_err_d;
      sq_prod_q    <= sq_prod_d;
      upd_sq_q     <= upd_sq_d;
      err_sq_sum_q <= err_sq_sum_d;
    end
  end
`else
  always_comb begin
    upd_valid_d = calc_valid;
    upd_err_d   = calc_err;
    sq_ovf      = 1'b0;
  end

  assign pipe_busy = calc_busy | upd_valid_q;
`endif

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && in_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (!pipe_busy) state_d = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Accumulators take one sample per cycle from the update register; a clear
  // never coincides with an update because the pipeline is empty in IDLE/DONE.
  always_comb begin
    r_cnt        = sat_add(64'(sample_cnt_q), 64'd1, CNT_W);
    r_ecnt       = sat_add(64'(err_cnt_q), (upd_err_q != '0) ? 64'd1 : 64'd0, CNT_W);
    r_sum        = sat_add(64'(err_sum_q), 64'(upd_err_q), SUM_W);
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    err_sum_d    = err_sum_q;
    err_max_d    = err_max_q;
    sat_d        = sat_q;
    if (clear) begin
      sample_cnt_d = '0;
      err_cnt_d    = '0;
      err_sum_d    = '0;
      err_max_d    = '0;
      sat_d        = 1'b0;
    end else if (upd_valid_q) begin
      sample_cnt_d = r_cnt.val[CNT_W-1:0];
      err_cnt_d    = r_ecnt.val[CNT_W-1:0];
      err_sum_d    = r_sum.val[SUM_W-1:0];
      if (upd_err_q > err_max_q) err_max_d = upd_err_q;
      sat_d = sat_q | r_cnt.ovf | r_ecnt.ovf | r_sum.ovf | sq_ovf;
    end
  end

  assign unused_sat_hi = ^{r_cnt.val[63:CNT_W], r_ecnt.val[63:CNT_W], r_sum.val[63:SUM_W]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      upd_valid_q  <= 1'b0;
      upd_err_q    <= '0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      err_sum_q    <= '0;
      err_max_q    <= '0;
      sat_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      upd_valid_q  <= upd_valid_d;
      upd_err_q    <= upd_err_d;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      err_sum_q    <= err_sum_d;
      err_max_q    <= err_max_d;
      sat_q        <= sat_d;
    end
  end

  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign err_sum    = err_sum_q;
  assign err_max    = err_max_q;
  assign sat        = sat_q;

endmodule
